adc_interface_ad7864: RTL

- Read-side counterpart to the board's parallel DAC writer; drives a 4-channel, 12-bit, parallel-output, simultaneous-sampling ADC (AD7864-style: CONVST, BUSY, CS, RD, DB[11:0]) to digitize memristor sense voltages.
- Sits on the same cs/op/addr host command bus as the DAC interface, with the same rdy/state status.
- Triggers one conversion, waits on BUSY, then reads back 1-4 channel words sequentially, one valid-tagged word per channel.

---
 rtl/adc_interface_ad7864.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_interface_ad7864.sv
// Read-side interface for a 4-channel, 12-bit, simultaneous-sampling parallel ADC
// (AD7864-style). Accepts start/abort commands from the shared cs/op/addr host bus,
// pulses CONVST, tracks BUSY through its high and low edges, then reads channels
// 0..last_ch over the CS/RD/DB bus. Each channel produces one valid-tagged word.
module adc_interface_ad7864 #(
    parameter int unsigned T_CONVST  = 2,    // CONVST low width in clk cycles (>=1)
    parameter int unsigned T_RD      = 3,    // RD/CS low width per word in clk cycles (>=2)
    parameter int unsigned T_TIMEOUT = 255   // max cycles for each BUSY edge wait
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic [3:0]  op,
    input  logic [7:0]  addr,
    output logic        rdy,
    output logic [3:0]  state,
    output logic [15:0] data_out,
    output logic        valid,
    output logic        timeout,
    output logic        CONVST,
    input  logic        BUSY,
    output logic        CS,
    output logic        RD,
    input  logic [11:0] DB
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CONVST  = 4'd1,
        S_WAIT_HI = 4'd2,
        S_WAIT_LO = 4'd3,
        S_READ    = 4'd4,
        S_GAP     = 4'd5,
        S_ERROR   = 4'd6
    } state_t;

    // Terminal counts for the shared 8-bit cycle counter.
    localparam logic [7:0] LP_CONVST_LAST = 8'(T_CONVST - 1);
    localparam logic [7:0] LP_RD_LAST     = 8'(T_RD - 1);
    localparam logic [7:0] LP_TO_LAST     = 8'(T_TIMEOUT - 1);

    state_t      r_state;
    logic        r_rdy;
    logic        r_convst_n;
    logic        r_cs_n;
    logic        r_rd_n;
    logic        r_valid;
    logic        r_timeout;
    logic [15:0] r_data_out;
    logic [7:0]  r_cnt;
    logic [1:0]  r_ch;
    logic [1:0]  r_last_ch;
    logic        r_busy_meta;
    logic        r_busy_sync;
    logic [11:0] r_db;

    logic        w_abort;
    logic        w_start;
    logic        w_unused;

    // Abort always wins over a simultaneous start.
    assign w_abort  = cs & op[0];
    assign w_start  = cs & op[1] & ~op[0];
    assign w_unused = ^{op[3:2], addr[7:2]};

    // Two-flop synchronizer for the asynchronous BUSY input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy_meta <= 1'b0;
            r_busy_sync <= 1'b0;
        end else begin
            r_busy_meta <= BUSY;
            r_busy_sync <= r_busy_meta;
        end
    end

    // Register the ADC data bus every cycle; the word is taken at the end of RD low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_db <= '0;
        end else begin
            r_db <= DB;
        end
    end

    // Conversion/readout sequencer with registered strobes and status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rdy      <= 1'b1;
            r_convst_n <= 1'b1;
            r_cs_n     <= 1'b1;
            r_rd_n     <= 1'b1;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_data_out <= '0;
            r_cnt      <= '0;
            r_ch       <= '0;
            r_last_ch  <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_abort && (r_state != S_ERROR)) begin
                r_state    <= S_IDLE;
                r_rdy      <= 1'b1;
                r_convst_n <= 1'b1;
                r_cs_n     <= 1'b1;
                r_rd_n     <= 1'b1;
                r_cnt      <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_last_ch  <= addr[1:0];
                            r_ch       <= '0;
                            r_rdy      <= 1'b0;
                            r_convst_n <= 1'b0;
                            r_cnt      <= '0;
                            r_state    <= S_CONVST;
                        end
                    end
                    S_CONVST: begin
                        if (r_cnt == LP_CONVST_LAST) begin
                            r_convst_n <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= S_WAIT_HI;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_WAIT_HI: begin
                        if (r_busy_sync) begin
                            r_cnt   <= '0;
                            r_state <= S_WAIT_LO;
                        end else if (r_cnt == LP_TO_LAST) begin
                            r_timeout  <= 1'b1;
                            r_rdy      <= 1'b0;
                            r_convst_n <= 1'b1;
                            r_cs_n     <= 1'b1;
                            r_rd_n     <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= S_ERROR;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_WAIT_LO: begin
                        if (!r_busy_sync) begin
                            r_cs_n  <= 1'b0;
                            r_rd_n  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_READ;
                        end else if (r_cnt == LP_TO_LAST) begin
                            r_timeout  <= 1'b1;
                            r_rdy      <= 1'b0;
                            r_convst_n <= 1'b1;
                            r_cs_n     <= 1'b1;
                            r_rd_n     <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= S_ERROR;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_READ: begin
                        if (r_cnt == LP_RD_LAST) begin
                            r_data_out <= {2'b00, r_ch, r_db};
                            r_valid    <= 1'b1;
                            r_rd_n     <= 1'b1;
                            r_cs_n     <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= S_GAP;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_GAP: begin
                        if (r_ch == r_last_ch) begin
                            r_rdy   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_ch    <= r_ch + 2'd1;
                            r_cs_n  <= 1'b0;
                            r_rd_n  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_READ;
                        end
                    end
                    S_ERROR: begin
                        if (w_abort) begin
                            r_timeout <= 1'b0;
                            r_rdy     <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: begin
                        r_rdy      <= 1'b1;
                        r_convst_n <= 1'b1;
                        r_cs_n     <= 1'b1;
                        r_rd_n     <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rdy      = r_rdy;
    assign state    = r_state;
    assign data_out = r_data_out;
    assign valid    = r_valid;
    assign timeout  = r_timeout;
    assign CONVST   = r_convst_n;
    assign CS       = r_cs_n;
    assign RD       = r_rd_n;

endmodule
